msg_rx: RTL and testbench
=========================

Name: msg_rx

Overview:
- Serial receiver for the wireless letter link. It is the receiving end of the byte stream whose transmit side raises msg_sent.
- It deserialises 8N1 UART frames from the radio module's RX pin and presents each good byte (an ASCII letter or a game-control code) to the player-side game FSM.
- The hand-off to the FSM uses a valid/ack handshake.
- Error events are reported on single-cycle pulses: framing, overrun, and optionally parity.

Parameters:
- CLKS_PER_BIT, 1250: system clocks per bit period (12 MHz / 9600 baud). Must be >= 8. Bench uses 16.
- DATA_BITS, 8: data bits per frame, sent LSB first.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rx_serial  in  1  raw serial line from the radio; idles high; asynchronous to clk
- rx_ack  in  1  FSM has consumed rx_data; sampled only while rx_valid=1
- rx_data  out  DATA_BITS  last good byte received
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_busy  out  1  a frame is in progress (any state except IDLE)
- framing_error  out  1  one-cycle pulse: stop bit sampled as 0
- overrun  out  1  one-cycle pulse: a good byte was dropped because rx_valid was still 1

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, framing_error=0, overrun=0, state=IDLE, bit counter=0, baud counter=0. Both synchroniser flops reset to 1 (line idle).
- rx_serial passes through a 2-flop synchroniser; rxs denotes the synchronised line. All sampling uses rxs.
- Baud counter width is $clog2(CLKS_PER_BIT). It is cleared on every state entry.
- IDLE: a falling edge on rxs (previous 1, current 0) moves to START. A line already low on exit from reset is not a start.
- START: wait CLKS_PER_BIT/2 (integer division) cycles to reach bit centre, then sample rxs.
  - rxs=0: go to DATA.
  - rxs=1: glitch; return to IDLE, no flags.
- DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit [bit_cnt], LSB first. After DATA_BITS samples go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rxs.
  - rxs=1: good frame; go to IDLE immediately (half-bit early, to allow back-to-back frames).
  - rxs=0: framing_error pulses for one cycle and the byte is discarded. Go to BREAK.
- BREAK: wait until rxs=1, then go to IDLE. This blocks false start detection during a held-low line.
- Good-frame delivery, in the cycle after the stop sample:
  - rx_valid=0, or rx_valid=1 with rx_ack=1 in the same cycle: load rx_data, rx_valid=1.
  - rx_valid=1 and rx_ack=0: keep the old rx_data, drop the new byte, overrun pulses for one cycle.
- rx_ack with rx_valid=1 and no delivery that cycle: rx_valid goes to 0 on the next edge. rx_ack with rx_valid=0 is ignored.
- Latency: rx_valid rises at most 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 2 cycles after the falling edge at the rx_serial pin.
- rx_data is never modified except on delivery.
- rst mid-frame: partial frame is abandoned, all outputs return to reset values; no flags pulse.

Optional Feature:
- Macro MSG_RX_PARITY_EN.
- Defined:
  - Frames carry an even-parity bit between the last data bit and the stop bit, handled by a PARITY state sampled at bit centre.
  - Extra output port parity_error (1 bit) pulses for one cycle when the XOR of the data bits and the parity bit is 1; that byte is discarded.
  - If the same frame also fails the stop bit, both pulses fire, in the same cycle, at stop sample time.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_error port; the frame is 8N1.

Decomposition:
- hangman_pkg holds:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - default constants CLKS_PER_BIT_DEF=1250 and DATA_BITS_DEF=8;
  - the game-control byte codes shared with the transmitter.
- One sub-module, msg_rx_sync: a 2-flop synchroniser with reset value parameterised (here 1).

Test Plan (CLKS_PER_BIT=16):
- Send 0x41 ('A'), stop=1 -> rx_data=0x41 and rx_valid=1 within 2+8+144+2=156 cycles of the start edge. No flags. rx_ack clears rx_valid on the next edge.
- Two back-to-back frames 0x50, 0x45 with no idle gap, rx_ack pulsed after the first -> rx_valid shows 0x50, then 0x45. No overrun.
- Send 0x50 then 0x4C without acking -> overrun pulses once, rx_data stays 0x50, rx_valid stays 1.
- Frame 0x4F with stop=0, line held low for 40 cycles -> framing_error pulses once, rx_valid stays 0, no spurious start. The next frame 0x52 is received correctly.
- 4-cycle low glitch on an idle line -> state returns to IDLE, rx_busy deasserts, no valid, no flags. Also: assert rst at bit 3 of a frame -> all outputs 0, and the next full frame is received correctly.
- With MSG_RX_PARITY_EN: 0x41 with parity 0 -> accepted. 0x41 with parity 1 -> parity_error pulses once, rx_valid=0.

Source files
------------

// File: rtl/hangman_pkg.sv
// hangman_pkg: definitions shared by the wireless letter link.
//   rx_state_t        : receiver FSM states (IDLE, START, DATA, PARITY, STOP, BREAK)
//   CLKS_PER_BIT_DEF  : default clocks per bit (12 MHz / 9600 baud)
//   DATA_BITS_DEF     : default data bits per frame
//   CODE_*            : game-control byte codes shared with the transmitter
package hangman_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 1250;
  localparam int DATA_BITS_DEF    = 8;

  // Control codes sit below printable ASCII so they never collide with letters.
  localparam logic [7:0] CODE_NEW_GAME = 8'h01;
  localparam logic [7:0] CODE_WIN      = 8'h02;
  localparam logic [7:0] CODE_LOSE     = 8'h03;
  localparam logic [7:0] CODE_ABORT    = 8'h04;

endpackage

// File: rtl/msg_rx_sync.sv
// msg_rx_sync: two-flop synchroniser for an asynchronous single-bit input.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, both flops load RST_VAL
//   d    : asynchronous input
//   q    : synchronised output
module msg_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/msg_rx.sv
// msg_rx: 8N1 UART receiver feeding the player-side game FSM.
//   clk, rst       : system clock, asynchronous active-high reset
//   rx_serial      : raw serial line from the radio (idles high, asynchronous)
//   rx_ack         : FSM consumed rx_data (only meaningful while rx_valid=1)
//   rx_data        : last good byte received
//   rx_valid       : rx_data holds an unconsumed byte
//   rx_busy        : a frame is in progress
//   framing_error  : one-cycle pulse, stop bit sampled low
//   overrun        : one-cycle pulse, good byte dropped because rx_valid was still set
//   parity_error   : (MSG_RX_PARITY_EN only) one-cycle pulse, even parity failed
// Build option: define MSG_RX_PARITY_EN to accept 8E1 frames with a parity check.
module msg_rx
  import hangman_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 framing_error,
  output logic                 overrun
`ifdef MSG_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_CNT_LAST = BW'(DATA_BITS - 1);

  logic                 rxs_s;
  logic                 rxs_prev_r;
  logic [1:0]           settle_r;
  logic                 armed_r;
  logic                 start_s;
  rx_state_t            state_r, state_nxt_s;
  logic [CW-1:0]        baud_r, baud_nxt_s;
  logic [BW-1:0]        bit_r, bit_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                 par_bad_r, par_bad_nxt_s;
  logic                 good_r, good_nxt_s;
  logic                 ferr_nxt_s;
`ifdef MSG_RX_PARITY_EN
  logic                 perr_nxt_s;

  // Even parity: data plus parity bit must contain an even number of ones.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  msg_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rxs_s)
  );

  // The synchroniser's reset value of 1 is synthetic; only a high level seen
  // after both stages hold real line data arms start detection, so a line that
  // is already low when reset ends is never taken as a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_prev_r <= 1'b1;
      settle_r   <= 2'b00;
      armed_r    <= 1'b0;
    end else begin
      rxs_prev_r <= rxs_s;
      settle_r   <= {settle_r[0], 1'b1};
      armed_r    <= armed_r | (settle_r[1] & rxs_s);
    end
  end

  assign start_s = armed_r & rxs_prev_r & ~rxs_s;

  // Next-state logic: every transition clears the baud counter.
  always_comb begin
    state_nxt_s   = state_r;
    baud_nxt_s    = baud_r;
    bit_nxt_s     = bit_r;
    shift_nxt_s   = shift_r;
    par_bad_nxt_s = par_bad_r;
    good_nxt_s    = 1'b0;
    ferr_nxt_s    = 1'b0;
`ifdef MSG_RX_PARITY_EN
    perr_nxt_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        baud_nxt_s    = '0;
        bit_nxt_s     = '0;
        par_bad_nxt_s = 1'b0;
        if (start_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (baud_r == HALF_LAST) begin
          baud_nxt_s = '0;
          // A line back high at the start-bit centre was only a glitch.
          if (rxs_s == 1'b0) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          baud_nxt_s = baud_r + CW'(1'b1);
        end
      end
      DATA: begin
        if (baud_r == BIT_LAST) begin
          baud_nxt_s  = '0;
          // LSB arrives first, so shift in from the top.
          shift_nxt_s = {rxs_s, shift_r[DATA_BITS-1:1]};
          if (bit_r == BIT_CNT_LAST) begin
            bit_nxt_s = '0;
`ifdef MSG_RX_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
          end else begin
            bit_nxt_s = bit_r + BW'(1'b1);
          end
        end else begin
          baud_nxt_s = baud_r + CW'(1'b1);
        end
      end
`ifdef MSG_RX_PARITY_EN
      PARITY: begin
        if (baud_r == BIT_LAST) begin
          baud_nxt_s    = '0;
          par_bad_nxt_s = parity_bad(shift_r, rxs_s);
          state_nxt_s   = STOP;
        end else begin
          baud_nxt_s = baud_r + CW'(1'b1);
        end
      end
`endif
      STOP: begin
        if (baud_r == BIT_LAST) begin
          baud_nxt_s = '0;
`ifdef MSG_RX_PARITY_EN
          perr_nxt_s = par_bad_r;
`endif
          // Leave at stop-bit centre so a back-to-back start edge is not missed.
          if (rxs_s == 1'b1) begin
            state_nxt_s = IDLE;
            good_nxt_s  = ~par_bad_r;
          end else begin
            state_nxt_s = BREAK;
            ferr_nxt_s  = 1'b1;
          end
        end else begin
          baud_nxt_s = baud_r + CW'(1'b1);
        end
      end
      BREAK: begin
        baud_nxt_s = '0;
        if (rxs_s == 1'b1) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BREAK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        baud_nxt_s  = '0;
      end
    endcase
  end

  // FSM state, counters, shift register and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      baud_r        <= '0;
      bit_r         <= '0;
      shift_r       <= '0;
      par_bad_r     <= 1'b0;
      good_r        <= 1'b0;
      rx_busy       <= 1'b0;
      framing_error <= 1'b0;
`ifdef MSG_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      baud_r        <= baud_nxt_s;
      bit_r         <= bit_nxt_s;
      shift_r       <= shift_nxt_s;
      par_bad_r     <= par_bad_nxt_s;
      good_r        <= good_nxt_s;
      rx_busy       <= (state_nxt_s != IDLE);
      framing_error <= ferr_nxt_s;
`ifdef MSG_RX_PARITY_EN
      parity_error  <= perr_nxt_s;
`endif
    end
  end

  // Hand-off to the game FSM: deliver, drop with overrun, or clear on ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (good_r) begin
        // An ack in the delivery cycle frees the slot for the new byte.
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msg_rx.sv
// tb_msg_rx: self-checking bench for msg_rx with CLKS_PER_BIT=16.
// Build option: MSG_RX_PARITY_EN adds the parity bit to every frame and the parity checks.
module tb_msg_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef MSG_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int LAT_MAX = 2 + CPB / 2 + (DB + 1 + PBITS) * CPB + 2;

  logic          tb_clk    = 1'b0;
  logic          rst       = 1'b1;
  logic          rx_serial = 1'b1;
  logic          rx_ack    = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          framing_error;
  logic          overrun;
`ifdef MSG_RX_PARITY_EN
  logic          parity_error;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int pe_cnt  = 0;
  bit bad_parity = 1'b0;

  always #5 tb_clk = ~tb_clk;

  msg_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .rx_serial     (rx_serial),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_busy       (rx_busy),
    .framing_error (framing_error),
    .overrun       (overrun)
`ifdef MSG_RX_PARITY_EN
    ,
    .parity_error  (parity_error)
`endif
  );

  // Count every cycle each error pulse is high.
  always @(negedge tb_clk) begin
    fe_cnt <= fe_cnt + ((framing_error === 1'b1) ? 1 : 0);
    ov_cnt <= ov_cnt + ((overrun === 1'b1) ? 1 : 0);
`ifdef MSG_RX_PARITY_EN
    pe_cnt <= pe_cnt + ((parity_error === 1'b1) ? 1 : 0);
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (rx_valid !== 1'b1 && cyc < budget) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  // Drive one frame; a bad stop bit holds the line low for low_hold cycles.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int low_hold);
    rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      rx_serial = d[i];
      tick(CPB);
    end
`ifdef MSG_RX_PARITY_EN
    rx_serial = (^d) ^ bad_parity;
    tick(CPB);
`endif
    if (stop_ok) begin
      rx_serial = 1'b1;
      tick(CPB);
    end else begin
      rx_serial = 1'b0;
      tick(low_hold);
      rx_serial = 1'b1;
      tick(CPB);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop_ok;
    bit         ack;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vt[8];

  initial begin
    int cyc, fe0, ov0, pe0, efe, eov;
    bit saw_busy, mv;
    logic [7:0] md, rd;
    bit rs;

    // Reset state.
    tick(4);
    check("rst_data", rx_data, 32'd0);
    check("rst_valid", rx_valid, 32'd0);
    check("rst_busy", rx_busy, 32'd0);
    check("rst_ferr", framing_error, 32'd0);
    check("rst_ovr", overrun, 32'd0);
    rst = 1'b0;
    tick(5);

    // 'A' with latency bound, then ack clears valid on the next edge.
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'h41, 1'b1, 0);
      wait_valid(400, cyc);
    join
    n_tests++;
    if (cyc > LAT_MAX) begin
      n_fail++;
      $display("FAIL latency_A: %0d cycles, limit %0d", cyc, LAT_MAX);
    end
    tick(3);
    check("A_valid", rx_valid, 32'd1);
    check("A_data", rx_data, 32'h41);
    check("A_flags", fe_cnt - fe0 + ov_cnt - ov0, 32'd0);
    pulse_ack();
    check("A_ack_clears", rx_valid, 32'd0);

    // Table: state entering is valid=0, data=0x41.
    vt[0] = '{8'h50, 1'b1, 1'b0, 1'b1, 8'h50, 0, 0};
    vt[1] = '{8'h4C, 1'b1, 1'b1, 1'b1, 8'h50, 0, 1};
    vt[2] = '{8'h4F, 1'b0, 1'b0, 1'b0, 8'h50, 1, 0};
    vt[3] = '{8'h52, 1'b1, 1'b1, 1'b1, 8'h52, 0, 0};
    vt[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0};
    vt[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 0, 0};
    vt[6] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0};
    vt[7] = '{8'h4F, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 0};
    for (int i = 0; i < 8; i++) begin
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(vt[i].d, vt[i].stop_ok, 40);
      tick(3);
      check($sformatf("vec%0d_valid", i), rx_valid, vt[i].exp_valid);
      check($sformatf("vec%0d_data", i), rx_data, vt[i].exp_data);
      check($sformatf("vec%0d_ferr", i), fe_cnt - fe0, vt[i].exp_fe);
      check($sformatf("vec%0d_ovr", i), ov_cnt - ov0, vt[i].exp_ov);
      check($sformatf("vec%0d_busy", i), rx_busy, 32'd0);
      if (vt[i].ack) begin
        pulse_ack();
        check($sformatf("vec%0d_ack", i), rx_valid, 32'd0);
      end
    end

    // Back-to-back frames, ack after the first.
    ov0 = ov_cnt;
    fork
      begin
        send_frame(8'h50, 1'b1, 0);
        send_frame(8'h45, 1'b1, 0);
      end
      begin
        wait_valid(400, cyc);
        check("b2b_first", rx_data, 32'h50);
        pulse_ack();
        wait_valid(400, cyc);
        check("b2b_second_valid", rx_valid, 32'd1);
        check("b2b_second", rx_data, 32'h45);
      end
    join
    tick(3);
    check("b2b_no_ovr", ov_cnt - ov0, 32'd0);
    pulse_ack();

    // Short glitch on an idle line.
    fe0 = fe_cnt; ov0 = ov_cnt; saw_busy = 1'b0;
    rx_serial = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (i == 4) rx_serial = 1'b1;
      tick(1);
      if (rx_busy === 1'b1) saw_busy = 1'b1;
    end
    check("glitch_seen_busy", saw_busy, 32'd1);
    check("glitch_busy", rx_busy, 32'd0);
    check("glitch_valid", rx_valid, 32'd0);
    check("glitch_flags", fe_cnt - fe0 + ov_cnt - ov0, 32'd0);

    // Line already low when reset ends is not a start.
    rx_serial = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(40);
    check("low_at_reset_busy", rx_busy, 32'd0);
    rx_serial = 1'b1;
    tick(10);
    check("low_at_reset_after", rx_busy, 32'd0);

    // Get a nonzero byte held, then reset in the middle of bit 3 of a frame.
    send_frame(8'h3C, 1'b1, 0);
    tick(3);
    fe0 = fe_cnt; ov0 = ov_cnt;
    rd = 8'h5A;
    rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_serial = rd[i];
      tick(CPB);
    end
    rx_serial = rd[3];
    tick(CPB / 2);
    check("midrst_busy_before", rx_busy, 32'd1);
    rst = 1'b1;
    rx_serial = 1'b1;
    tick(1);
    check("midrst_busy", rx_busy, 32'd0);
    check("midrst_valid", rx_valid, 32'd0);
    check("midrst_data", rx_data, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(5);
    send_frame(8'h33, 1'b1, 0);
    tick(3);
    check("after_rst_valid", rx_valid, 32'd1);
    check("after_rst_data", rx_data, 32'h33);
    check("after_rst_flags", fe_cnt - fe0 + ov_cnt - ov0, 32'd0);
    pulse_ack();

    // Randomised frames against a transaction-level model.
    mv = 1'b0; md = 8'h33; efe = 0; eov = 0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs, int'($urandom_range(12, 40)));
      if (rs) begin
        if (mv) begin
          eov++;
        end else begin
          md = rd;
          mv = 1'b1;
        end
      end else begin
        efe++;
      end
      tick(3);
      check($sformatf("rnd%0d_valid", i), rx_valid, mv);
      check($sformatf("rnd%0d_data", i), rx_data, md);
      check($sformatf("rnd%0d_ferr", i), fe_cnt - fe0, efe);
      check($sformatf("rnd%0d_ovr", i), ov_cnt - ov0, eov);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        mv = 1'b0;
      end
      tick(int'($urandom_range(0, 10)));
    end
    if (mv) pulse_ack();

`ifdef MSG_RX_PARITY_EN
    // Parity: good frame, bad parity, and bad parity with bad stop.
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h41, 1'b1, 0);
    tick(3);
    check("par_ok_valid", rx_valid, 32'd1);
    check("par_ok_data", rx_data, 32'h41);
    check("par_ok_perr", pe_cnt - pe0, 32'd0);
    pulse_ack();
    bad_parity = 1'b1;
    send_frame(8'h41, 1'b1, 0);
    tick(3);
    check("par_bad_valid", rx_valid, 32'd0);
    check("par_bad_perr", pe_cnt - pe0, 32'd1);
    send_frame(8'h41, 1'b0, 30);
    tick(3);
    check("par_stop_perr", pe_cnt - pe0, 32'd2);
    check("par_stop_ferr", fe_cnt - fe0, 32'd1);
    check("par_stop_valid", rx_valid, 32'd0);
    bad_parity = 1'b0;
`else
    pe0 = pe_cnt;
    check("no_parity_pulses", pe_cnt - pe0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish, %0d tests so far", n_tests);
    $fatal(1);
  end

endmodule
